// File: rtl/mux_pkg.sv
// Shared select encodings for the 4:1 data multiplexer.
package mux_pkg;

   localparam logic [1:0] SEL_I0 = 2'b00;
   localparam logic [1:0] SEL_I1 = 2'b01;
   localparam logic [1:0] SEL_I2 = 2'b10;
   localparam logic [1:0] SEL_I3 = 2'b11;

endpackage : mux_pkg

// File: rtl/mux_sel_comb.sv
// Combinational 4:1 selector.
// An unknown select drives X rather than silently picking an input.
module mux_sel_comb
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [1:0]       sel_i,
   input  logic [WIDTH-1:0] d0_i,
   input  logic [WIDTH-1:0] d1_i,
   input  logic [WIDTH-1:0] d2_i,
   input  logic [WIDTH-1:0] d3_i,
   output logic [WIDTH-1:0] y_o
);

   // Pick the input addressed by sel_i; X/Z select falls to the X default.
   always_comb begin
      y_o = 'x;
      case (sel_i)
         SEL_I0:  y_o = d0_i;
         SEL_I1:  y_o = d1_i;
         SEL_I2:  y_o = d2_i;
         SEL_I3:  y_o = d3_i;
         default: y_o = 'x;
      endcase
   end

endmodule : mux_sel_comb

// File: rtl/mux_4to1.sv
// 4:1 multiplexer with a live combinational output (OUT), a registered copy
// (OUT_Q) and a one-cycle change pulse (CHG). Reset touches only the
// registered path; OUT stays live throughout.
module mux_4to1
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   output logic [WIDTH-1:0] OUT,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I2,
   input  logic [WIDTH-1:0] I3,
   input  logic             SEL0,
   input  logic             SEL1,
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] OUT_Q,
   output logic             CHG
);

   logic [WIDTH-1:0] out_q_q, out_q_d;
   logic             chg_q, chg_d;

   mux_sel_comb #(.WIDTH(WIDTH)) u_sel (
      .sel_i ({SEL1, SEL0}),
      .d0_i  (I0),
      .d1_i  (I1),
      .d2_i  (I2),
      .d3_i  (I3),
      .y_o   (OUT)
   );

   // Next state: capture OUT; flag a change against the value held before the edge.
   always_comb begin
      out_q_d = OUT;
      chg_d   = (OUT != out_q_q);
   end

   // Registered copy and change pulse, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q_q <= '0;
         chg_q   <= 1'b0;
      end else begin
         out_q_q <= out_q_d;
         chg_q   <= chg_d;
      end
   end

   assign OUT_Q = out_q_q;
   assign CHG   = chg_q;

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: directed cases plus randomized traffic
// checked against an array-indexed reference with a one-entry history.
module tb_mux_4to1;

   localparam int W = 4;

   logic [W-1:0] OUT, I0, I1, I2, I3, OUT_Q;
   logic         SEL0, SEL1, clk, rst_n, CHG;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] din [4];
   logic [1:0]   sel;
   logic [W-1:0] mdl_q;
   logic         mdl_chg;

   mux_4to1 #(.WIDTH(W)) dut (
      .OUT(OUT), .I0(I0), .I1(I1), .I2(I2), .I3(I3),
      .SEL0(SEL0), .SEL1(SEL1), .clk(clk), .rst_n(rst_n),
      .OUT_Q(OUT_Q), .CHG(CHG)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      I0 = din[0]; I1 = din[1]; I2 = din[2]; I3 = din[3];
      SEL0 = sel[0]; SEL1 = sel[1];
   endtask

   function automatic logic [W-1:0] ref_out();
      return din[sel];
   endfunction

   // One clock: predict the registered state, let the edge pass, compare.
   task automatic tick();
      logic [W-1:0] nq;
      nq      = ref_out();
      mdl_chg = (nq != mdl_q);
      mdl_q   = nq;
      @(posedge clk);
      #1;
      chk("OUT_Q", OUT_Q, mdl_q);
      chk("CHG", W'(CHG), W'(mdl_chg));
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      din = '{default: '0};
      sel = 2'b00;
      drive();
      mdl_q = '0;
      #3;
      chk("rst_OUT_Q", OUT_Q, '0);
      chk("rst_CHG", W'(CHG), '0);

      // Directed select sweep, no clock edge needed.
      din = '{W'(1), W'(0), W'(1), W'(0)};
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         drive();
         #1;
         chk("sweep_OUT", OUT, ref_out());
      end

      // Exhaustive per-lane patterns with reset held: OUT live, registers cleared.
      for (int p = 0; p < 16; p++) begin
         for (int k = 0; k < 4; k++) din[k] = W'(p >> k) & W'(1);
         for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            drive();
            #2;
            chk("exh_OUT", OUT, ref_out());
            chk("rsthold_OUT_Q", OUT_Q, '0);
            chk("rsthold_CHG", W'(CHG), '0);
         end
      end

      // Reset release sequence.
      @(negedge clk);
      din = '{W'(1), W'(0), W'(1), W'(0)};
      sel = 2'b00;
      drive();
      mdl_q = '0;
      rst_n = 1'b1;
      tick();                       // OUT_Q=1, CHG=1
      tick();                       // no change, CHG=0
      sel = 2'b01; drive();
      tick();                       // OUT_Q=0, CHG=1
      sel = 2'b00; drive();
      tick();                       // OUT_Q=1

      // Async reset between edges.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_OUT_Q", OUT_Q, '0);
      chk("async_CHG", W'(CHG), '0);
      chk("async_OUT_live", OUT, ref_out());
      mdl_q = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic with mid-cycle glitches and occasional resets.
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < 4; k++) din[k] = W'($urandom);
         sel = 2'($urandom_range(0, 3));
         drive();
         #1;
         chk("rnd_OUT", OUT, ref_out());
         if ($urandom_range(0, 3) == 0) begin
            // Glitch on the inputs, then settle before the edge.
            I0 = ~I0; SEL0 = ~SEL0;
            #1;
            drive();
            #1;
         end
         if ($urandom_range(0, 29) == 0) begin
            rst_n = 1'b0;
            #1;
            chk("rnd_rst_OUT_Q", OUT_Q, '0);
            chk("rnd_rst_CHG", W'(CHG), '0);
            mdl_q = '0;
            rst_n = 1'b1;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mux_4to1
